booth_seq_ctrl: RTL

//   Sequential radix-2 Booth multiplier controller. Time-shares one (N+1)-bit

---
 rtl/booth_pkg.sv | 30 +++
 rtl/booth_addsub.sv | 27 ++
 rtl/booth_seq_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential radix-2 Booth multiplier.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Booth recoding of {Qr[0], q_m1}
  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;

  function automatic logic [1:0] booth_op(input logic q0, input logic qm1);
    logic [1:0] op;
    op = OP_NOP;
    if (!q0 && qm1) op = OP_ADD;
    if (q0 && !qm1) op = OP_SUB;
    return op;
  endfunction

  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/booth_addsub.sv
// Ripple-carry add/subtract of W-bit operands; sub=1 computes a + ~b + 1.
module booth_addsub #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum
);

  logic [W-1:0] carry;
  logic [W-1:0] bx;

  assign carry[0] = sub;

  // Carry out of the top cell is discarded, so only W-1 carries are built.
  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_fa
      assign bx[gi]  = b[gi] ^ sub;
      assign sum[gi] = a[gi] ^ bx[gi] ^ carry[gi];
      if (gi < W - 1) begin : g_carry
        assign carry[gi+1] = (a[gi] & bx[gi]) | (carry[gi] & (a[gi] ^ bx[gi]));
      end
    end
  endgenerate

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth multiplier: one add/sub + shift per clock.
// Optional BOOTH_EARLY_EXIT_EN finishes as soon as remaining steps are shift-only.
module booth_seq_ctrl
  import booth_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product,
  output logic           busy
);

  localparam int CW = (clog2(N) < 1) ? 1 : clog2(N);

  state_t         state_reg;
  logic [N:0]     a_reg;
  logic [N:0]     mx_reg;
  logic [N-1:0]   q_reg;
  logic           qm1_reg;
  logic [CW-1:0]  cnt_reg;
  logic [2*N-1:0] product_reg;
  logic           out_valid_reg;

  logic [1:0]     op;
  logic           sub_en;
  logic [N:0]     sum;
  logic [N:0]     s;
  logic [N:0]     a_next;
  logic [N-1:0]   q_next;
  logic           qm1_next;
  logic           last;
  logic [2*N-1:0] product_next;

  assign op     = booth_op(q_reg[0], qm1_reg);
  assign sub_en = (op == OP_SUB);

  booth_addsub #(.W(N+1)) u_addsub (
    .a   (a_reg),
    .b   (mx_reg),
    .sub (sub_en),
    .sum (sum)
  );

  assign s        = (op == OP_NOP) ? a_reg : sum;
  assign a_next   = {s[N], s[N:1]};
  assign q_next   = {s[0], q_reg[N-1:1]};
  assign qm1_next = q_reg[0];

`ifdef BOOTH_EARLY_EXIT_EN
  logic [N-1:0]   quiet;
  logic signed [2*N:0] aq;
  logic [CW-1:0]  shamt;

  // Bit j is still unprocessed after this step when j + cnt + 2 <= N; once all
  // of those equal the new q_m1, every later Booth step is a pure shift.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_quiet
      assign quiet[gi] = ((gi + 2 + int'(cnt_reg)) > N) || (q_next[gi] == qm1_next);
    end
  endgenerate

  assign last         = &quiet;
  assign aq           = {a_next, q_next};
  assign shamt        = CW'(N - 1) - cnt_reg;
  assign product_next = (2*N)'(aq >>> shamt);
`else
  assign last         = (cnt_reg == CW'(N - 1));
  assign product_next = {a_next[N-1:0], q_next};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      a_reg         <= '0;
      mx_reg        <= '0;
      q_reg         <= '0;
      qm1_reg       <= 1'b0;
      cnt_reg       <= '0;
      product_reg   <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= '0;
            mx_reg    <= {multiplicand[N-1], multiplicand};
            q_reg     <= multiplier;
            qm1_reg   <= 1'b0;
            cnt_reg   <= '0;
            state_reg <= CALC;
          end
        end
        CALC: begin
          a_reg   <= a_next;
          q_reg   <= q_next;
          qm1_reg <= qm1_next;
          cnt_reg <= cnt_reg + CW'(1);
          if (last) begin
            product_reg   <= product_next;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign out_valid = out_valid_reg;
  assign product   = product_reg;

endmodule
